// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port, fixed-latency SRAM between the IF
// stage (read-only instruction fetch) and the MEM stage (load/store).
//
// Each access is granted in IDLE, runs for WAIT_CYCLES clocks in BUSY with the
// SRAM pins held stable, and ends with a one-cycle ready pulse in DONE. MEM has
// fixed priority over IF. freeze stalls the pipeline while any request waits.
//
// Optional feature: define MEM_ARB_PERF_EN to build a saturating freeze-cycle
// counter on stall_cycles; without it stall_cycles is tied to zero.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   if_req/if_addr             fetch request (level, held until if_ready)
//   if_ready/if_rdata          fetch done pulse / fetched word
//   mem_req/mem_we/mem_addr/mem_wdata  data request, 1 = store
//   mem_ready/mem_rdata        data done pulse / load data
//   freeze                     pipeline hold, combinational
//   sram_addr/sram_wdata/sram_we/sram_oe/sram_rdata  external SRAM pins
//   stall_cycles               freeze-cycle counter (MEM_ARB_PERF_EN)

module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 17,
    parameter int WAIT_CYCLES = 4    // legal range >= 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [31:0]       stall_cycles
);

    // Counter counts WAIT_CYCLES-1 down to 0; keep it at least one bit wide.
    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_MEM} grant_t;

    state_t           state;
    grant_t           grant;
    logic [CNT_W-1:0] cnt;

    // A request stays "outstanding" until the cycle its ready pulse is seen,
    // so the pipeline resumes in the same cycle it consumes the data.
    assign freeze = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below reads the pre-edge values (e.g. sram_we as the latched we).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            cnt        <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            sram_oe    <= 1'b0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            // NOTE: the rdata holding registers are ordinary flops, not a RAM,
            // so they are cleared with everything else.
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Operands are latched here and held for the whole access,
                    // so requester changes during BUSY have no effect.
                    if (mem_req) begin
                        grant      <= GNT_MEM;
                        sram_addr  <= mem_addr;
                        sram_wdata <= mem_wdata;
                        sram_we    <= mem_we;
                        sram_oe    <= ~mem_we;
                        cnt        <= CNT_LOAD;
                        state      <= BUSY;
                    end else if (if_req) begin
                        grant      <= GNT_IF;
                        sram_addr  <= if_addr;
                        sram_wdata <= '0;
                        sram_we    <= 1'b0;
                        sram_oe    <= 1'b1;
                        cnt        <= CNT_LOAD;
                        state      <= BUSY;
                    end
                end

                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Last BUSY cycle: read data is valid on the pins now.
                        if (!sram_we) begin
                            if (grant == GNT_MEM) begin
                                mem_rdata <= sram_rdata;
                            end else if (grant == GNT_IF) begin
                                if_rdata <= sram_rdata;
                            end
                        end
                        sram_we   <= 1'b0;
                        sram_oe   <= 1'b0;
                        if_ready  <= (grant == GNT_IF);
                        mem_ready <= (grant == GNT_MEM);
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // Ready pulses even if the requester withdrew (flush).
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    grant     <= GNT_NONE;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Saturating count of clock edges on which the pipeline was frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (freeze && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Instance u_dut uses WAIT_CYCLES=4 with a
// small read/write SRAM model; instance u_dut1 uses WAIT_CYCLES=1 with a
// read-only pattern SRAM. Expected completions are queued when a request is
// driven and popped when the DUT pulses a ready.

module tb_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 17;
    localparam int WAIT0  = 4;
    localparam int WAIT1  = 1;

`ifdef MEM_ARB_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd11;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance 0 (WAIT_CYCLES = 4) ----------------
    logic              if_req, if_ready, mem_req, mem_we, mem_ready, freeze;
    logic              sram_we, sram_oe;
    logic [ADDR_W-1:0] if_addr, mem_addr, sram_addr;
    logic [DATA_W-1:0] if_rdata, mem_wdata, mem_rdata, sram_wdata, sram_rdata;
    logic [31:0]       stall_cycles;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT0)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .freeze(freeze),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
        .sram_oe(sram_oe), .sram_rdata(sram_rdata), .stall_cycles(stall_cycles)
    );

    // ---------------- instance 1 (WAIT_CYCLES = 1) ----------------
    logic              if_req1, if_ready1, mem_req1, mem_we1, mem_ready1, freeze1;
    logic              sram_we1, sram_oe1;
    logic [ADDR_W-1:0] if_addr1, mem_addr1, sram_addr1;
    logic [DATA_W-1:0] if_rdata1, mem_wdata1, mem_rdata1, sram_wdata1, sram_rdata1;
    logic [31:0]       stall_cycles1;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ready(mem_ready1), .mem_rdata(mem_rdata1), .freeze(freeze1),
        .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_we(sram_we1),
        .sram_oe(sram_oe1), .sram_rdata(sram_rdata1), .stall_cycles(stall_cycles1)
    );

    // Initial SRAM contents: a fixed pattern, with the load target of the
    // first test holding 0xDEADBEEF.
    function automatic logic [31:0] pattern(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(32'h10)) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // SRAM model for instance 0 (256 words, low address bits).
    bit [31:0]  sram_arr [256];
    bit [255:0] written;
    always @(posedge clk) begin
        if (sram_we === 1'b1) begin
            sram_arr[sram_addr[7:0]] <= sram_wdata;
            written[sram_addr[7:0]]  <= 1'b1;
        end
    end
    assign sram_rdata = (sram_oe !== 1'b1)      ? '0 :
                        written[sram_addr[7:0]] ? sram_arr[sram_addr[7:0]] :
                                                  pattern(sram_addr);

    // Read-only pattern SRAM for instance 1.
    assign sram_rdata1 = (sram_oe1 === 1'b1) ? pattern(sram_addr1) : '0;

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [int];
    logic [31:0] exp_mem_rd;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_if_rd1;

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
        int          cycle;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pattern(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue_mem(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input int lat);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        if (we) ref_mem[int'(a)] = d;
        else    exp_mem_rd = ref_read(a);
        sb.push_back('{is_mem: 1'b1, data: exp_mem_rd, cycle: cyc + lat});
    endtask

    task automatic issue_if(input logic [ADDR_W-1:0] a, input int lat);
        if_req    = 1'b1;
        if_addr   = a;
        exp_if_rd = ref_read(a);
        sb.push_back('{is_mem: 1'b0, data: exp_if_rd, cycle: cyc + lat});
    endtask

    task automatic issue_if1(input logic [ADDR_W-1:0] a, input int lat);
        if_req1    = 1'b1;
        if_addr1   = a;
        exp_if_rd1 = pattern(a);
        sb.push_back('{is_mem: 1'b0, data: exp_if_rd1, cycle: cyc + lat});
    endtask

    // Called in a cycle where a ready is expected: pop and compare.
    task automatic expect_ready(input bit inst);
        exp_t        e;
        logic        ir, mr;
        logic [31:0] id, md;
        ir = inst ? if_ready1 : if_ready;
        mr = inst ? mem_ready1 : mem_ready;
        id = inst ? if_rdata1 : if_rdata;
        md = inst ? mem_rdata1 : mem_rdata;
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ready_is_mem", 32'(mr), 32'(e.is_mem));
            check("ready_only_one", 32'(ir & mr), 32'd0);
            check("ready_rdata", e.is_mem ? md : id, e.data);
            check("ready_cycle", 32'(cyc), 32'(e.cycle));
        end
    endtask

    // Bounded wait for any ready on an instance; returns at that cycle's negedge.
    task automatic wait_ready(input bit inst, input bit chk_freeze, input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            sample();
            if ((inst ? (if_ready1 | mem_ready1) : (if_ready | mem_ready)) === 1'b1) begin
                got = 1'b1;
            end else begin
                if (chk_freeze) check("freeze_while_pending", 32'(inst ? freeze1 : freeze), 32'd1);
                tick();
            end
        end
        check("ready_seen", 32'(got), 32'd1);
        if (got) expect_ready(inst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0; if_addr   = '0;
        mem_req   = 1'b0; mem_we    = 1'b0; mem_addr  = '0; mem_wdata  = '0;
        if_req1   = 1'b0; if_addr1  = '0;
        mem_req1  = 1'b0; mem_we1   = 1'b0; mem_addr1 = '0; mem_wdata1 = '0;
        exp_mem_rd = '0; exp_if_rd = '0; exp_if_rd1 = '0;

        // ---- reset state ----
        tick(); tick();
        sample();
        check("rst_if_ready",     32'(if_ready),   32'd0);
        check("rst_mem_ready",    32'(mem_ready),  32'd0);
        check("rst_if_rdata",     if_rdata,        32'd0);
        check("rst_mem_rdata",    mem_rdata,       32'd0);
        check("rst_sram_we",      32'(sram_we),    32'd0);
        check("rst_sram_oe",      32'(sram_oe),    32'd0);
        check("rst_sram_addr",    32'(sram_addr),  32'd0);
        check("rst_sram_wdata",   sram_wdata,      32'd0);
        check("rst_stall",        stall_cycles,    32'd0);
        check("rst1_if_ready",    32'(if_ready1),  32'd0);
        tick();
        rst = 1'b0;
        tick();

        // ---- 1: load 0x10 ----
        issue_mem(1'b0, ADDR_W'(32'h10), 32'd0, WAIT0 + 1);
        for (int k = 0; k <= WAIT0 + 1; k++) begin
            sample();
            if (k <= WAIT0) begin
                check("s1_freeze", 32'(freeze), 32'd1);
                check("s1_no_ready", 32'(mem_ready), 32'd0);
            end
            if (k >= 1 && k <= WAIT0) begin
                check("s1_sram_oe", 32'(sram_oe), 32'd1);
                check("s1_sram_addr", 32'(sram_addr), 32'h10);
            end
            if (k == WAIT0 + 1) begin
                expect_ready(1'b0);
                check("s1_freeze_at_ready", 32'(freeze), 32'd0);
                check("s1_oe_done", 32'(sram_oe), 32'd0);
            end
            tick();
        end
        mem_req = 1'b0;

        // ---- 2: store 0x20 (mem_rdata must keep the load value) ----
        tick();
        issue_mem(1'b1, ADDR_W'(32'h20), 32'h1234_5678, WAIT0 + 1);
        for (int k = 0; k <= WAIT0 + 1; k++) begin
            sample();
            if (k >= 1 && k <= WAIT0) begin
                check("s2_we", 32'(sram_we), 32'd1);
                check("s2_oe", 32'(sram_oe), 32'd0);
                check("s2_addr", 32'(sram_addr), 32'h20);
                check("s2_wdata", sram_wdata, 32'h1234_5678);
            end else begin
                check("s2_we_outside", 32'(sram_we), 32'd0);
            end
            if (k == WAIT0 + 1) expect_ready(1'b0);
            tick();
        end
        mem_req = 1'b0;

        // ---- flush: store 0x50, request withdrawn and operands changed mid-access ----
        tick();
        issue_mem(1'b1, ADDR_W'(32'h50), 32'hAABB_CCDD, WAIT0 + 1);
        tick(); tick();
        mem_req   = 1'b0;
        mem_addr  = ADDR_W'(32'h77);
        mem_wdata = 32'h0;
        sample();
        check("flush_addr_held", 32'(sram_addr), 32'h50);
        check("flush_wdata_held", sram_wdata, 32'hAABB_CCDD);
        tick();
        wait_ready(1'b0, 1'b0, 10);
        tick();

        // ---- read back both stores ----
        issue_mem(1'b0, ADDR_W'(32'h50), 32'd0, WAIT0 + 1);
        wait_ready(1'b0, 1'b1, 10);
        tick();
        mem_req = 1'b0;
        tick();
        issue_mem(1'b0, ADDR_W'(32'h20), 32'd0, WAIT0 + 1);
        wait_ready(1'b0, 1'b1, 10);
        tick();
        mem_req = 1'b0;

        // ---- 3 + 6: simultaneous requests, MEM first, stall count ----
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_mem_rd = '0;
        exp_if_rd  = '0;
        issue_mem(1'b0, ADDR_W'(32'h60), 32'd0, WAIT0 + 1);
        issue_if(ADDR_W'(32'h61), 2 * WAIT0 + 3);
        wait_ready(1'b0, 1'b1, 10);
        tick();
        mem_req = 1'b0;
        wait_ready(1'b0, 1'b1, 10);
        check("s3_stall_cycles", stall_cycles, EXP_STALL);
        check("s3_freeze_at_if_ready", 32'(freeze), 32'd0);
        tick();
        if_req = 1'b0;

        // ---- 4: reset in cycle 2 of a load ----
        tick();
        issue_mem(1'b0, ADDR_W'(32'h10), 32'd0, WAIT0 + 1);
        tick(); tick();
        rst     = 1'b1;
        mem_req = 1'b0;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        exp_mem_rd = '0;
        exp_if_rd  = '0;
        sample();
        check("s4_oe_after_rst", 32'(sram_oe), 32'd0);
        check("s4_we_after_rst", 32'(sram_we), 32'd0);
        check("s4_no_ready", 32'(mem_ready), 32'd0);
        check("s4_mem_rdata_cleared", mem_rdata, 32'd0);
        tick();
        issue_if(ADDR_W'(32'h21), WAIT0 + 1);
        wait_ready(1'b0, 1'b1, 10);
        tick();
        if_req = 1'b0;

        // ---- 5: WAIT_CYCLES=1, back-to-back fetches 0x0 then 0x1 ----
        tick();
        issue_if1(ADDR_W'(32'h0), WAIT1 + 1);
        wait_ready(1'b1, 1'b1, 6);
        tick();
        issue_if1(ADDR_W'(32'h1), WAIT1 + 1);
        wait_ready(1'b1, 1'b1, 6);
        tick();
        if_req1 = 1'b0;

        tick(); tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
